// File: rtl/i2c_reg_bank_if.sv
// Bus bundle between the I2C byte receiver / local readback user and the
// register bank. The bank is the slave; the receiver side is the master.
interface i2c_reg_bank_if #(
  parameter int NUM_REGS = 8
);
  logic [7:0]            data_i;
  logic                  data_valid_i;
  logic                  start_i;
  logic                  stop_i;
  logic [3:0]            rd_addr_i;
  logic [7:0]            rd_data_o;
  logic [8*NUM_REGS-1:0] regs_o;
  logic                  wr_strobe_o;
  logic [3:0]            wr_addr_o;
  logic                  busy_o;
  logic                  err_o;

  modport master (
    output data_i, data_valid_i, start_i, stop_i, rd_addr_i,
    input  rd_data_o, regs_o, wr_strobe_o, wr_addr_o, busy_o, err_o
  );

  modport slave (
    input  data_i, data_valid_i, start_i, stop_i, rd_addr_i,
    output rd_data_o, regs_o, wr_strobe_o, wr_addr_o, busy_o, err_o
  );
endinterface

// File: rtl/i2c_reg_bank.sv
// Write decoder and register file fed by the I2C slave receiver.
// First byte after start is the register pointer; following bytes are
// written to consecutive registers with the pointer wrapping at NUM_REGS.
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | no transaction open
// PTR     | transaction open, waiting for pointer byte
// DATA    | writing registers, pointer auto-increments
// DROP    | bad pointer seen, discard bytes until start/stop
module i2c_reg_bank #(
  parameter int          NUM_REGS    = 8,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  i2c_reg_bank_if.slave  bus
);

  localparam int         PTR_W = $clog2(NUM_REGS);
  localparam logic [7:0] LIMIT = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_dv_q;
  logic [7:0]       r_regs [NUM_REGS];
  logic [7:0]       r_rd_data;
  logic             r_wr_strobe;
  logic [3:0]       r_wr_addr;
  logic             r_err;

  logic w_byte_evt;
  logic w_ptr_ok;
  logic w_rd_ok;

  // A byte is announced only by the rising edge of the valid level.
  assign w_byte_evt = bus.data_valid_i & ~r_dv_q;
  assign w_ptr_ok   = (bus.data_i < LIMIT);
  assign w_rd_ok    = ({4'b0000, bus.rd_addr_i} < LIMIT);

  // Transaction FSM, pointer, register writes and write/error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_dv_q      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 4'h0;
      r_err       <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VALUE;
    end else begin
      r_dv_q      <= bus.data_valid_i;
      r_wr_strobe <= 1'b0;
      if (bus.start_i) begin
        // Start (or repeated start) wins over a coincident byte and stop.
        r_state <= ST_PTR;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_PTR: begin
            if (w_byte_evt) begin
              if (w_ptr_ok) begin
                r_ptr   <= bus.data_i[PTR_W-1:0];
                r_state <= ST_DATA;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_DROP;
              end
            end
          end
          ST_DATA: begin
            if (w_byte_evt) begin
              r_regs[r_ptr] <= bus.data_i;
              r_ptr         <= r_ptr + PTR_W'(1);
              r_wr_strobe   <= 1'b1;
              r_wr_addr     <= 4'(r_ptr);
            end
          end
          default: ;
        endcase
        // A coincident byte is still processed above; stop only closes.
        if (bus.stop_i) r_state <= ST_IDLE;
      end
    end
  end

  // Registered readback; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else if (w_rd_ok) begin
      r_rd_data <= r_regs[bus.rd_addr_i[PTR_W-1:0]];
    end else begin
      r_rd_data <= 8'h00;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign bus.regs_o[8*g +: 8] = r_regs[g];
    end
  endgenerate

  assign bus.rd_data_o   = r_rd_data;
  assign bus.wr_strobe_o = r_wr_strobe;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank with a transaction-level reference model
// checked every cycle, plus literal checks on key results.
module tb_i2c_reg_bank;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   run_cmp = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  i2c_reg_bank_if #(.NUM_REGS(N)) bus ();

  i2c_reg_bank #(.NUM_REGS(N), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_regs [N];
  bit         m_open, m_want_ptr, m_drop, m_err, m_prev_dv;
  int         m_ptr;
  bit         m_strobe;
  logic [3:0] m_wr_addr;
  logic [7:0] m_rd;

  always @(posedge clk or posedge reset) begin
    bit evt;
    if (reset) begin
      for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
      m_open = 0; m_want_ptr = 0; m_drop = 0; m_err = 0; m_prev_dv = 0;
      m_ptr = 0; m_strobe = 0; m_wr_addr = 4'h0; m_rd = 8'h00;
    end else begin
      evt = bus.data_valid_i && !m_prev_dv;
      m_prev_dv = bus.data_valid_i;
      m_rd = (int'(bus.rd_addr_i) < N) ? m_regs[bus.rd_addr_i] : 8'h00;
      m_strobe = 0;
      if (bus.start_i) begin
        m_open = 1; m_want_ptr = 1; m_drop = 0; m_err = 0;
      end else begin
        if (m_open && evt) begin
          if (m_want_ptr) begin
            m_want_ptr = 0;
            if (int'(bus.data_i) < N) m_ptr = int'(bus.data_i);
            else begin m_err = 1; m_drop = 1; end
          end else if (!m_drop) begin
            m_regs[m_ptr] = bus.data_i;
            m_strobe = 1;
            m_wr_addr = 4'(m_ptr);
            m_ptr = (m_ptr + 1) % N;
          end
        end
        if (bus.stop_i) m_open = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [8*N-1:0] flat;
    if (run_cmp && !reset) begin
      for (int k = 0; k < N; k++) flat[8*k +: 8] = m_regs[k];
      chk("rd_data", 64'(bus.rd_data_o), 64'(m_rd));
      chk("regs", 64'(bus.regs_o), 64'(flat));
      chk("wr_strobe", 64'(bus.wr_strobe_o), 64'(m_strobe));
      chk("wr_addr", 64'(bus.wr_addr_o), 64'(m_wr_addr));
      chk("busy", 64'(bus.busy_o), 64'(m_open));
      chk("err", 64'(bus.err_o), 64'(m_err));
    end
  end

  // Write log for literal checks of strobe count and address order.
  int wq[$];
  always @(posedge clk) begin
    #1;
    if (!reset && bus.wr_strobe_o) wq.push_back(int'(bus.wr_addr_o));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    bus.data_i = b;
    bus.data_valid_i = 1'b1;
    tick(hold);
    bus.data_valid_i = 1'b0;
    tick(2);
  endtask

  task automatic do_start(input int width);
    bus.start_i = 1'b1;
    tick(width);
    bus.start_i = 1'b0;
    tick(1);
  endtask

  task automatic do_stop(input int width);
    bus.stop_i = 1'b1;
    tick(width);
    bus.stop_i = 1'b0;
    tick(1);
  endtask

  function automatic logic [7:0] reg_of(input int k);
    return bus.regs_o[8*k +: 8];
  endfunction

  initial begin
    bus.data_i = 8'h00; bus.data_valid_i = 1'b0; bus.start_i = 1'b0;
    bus.stop_i = 1'b0;  bus.rd_addr_i = 4'h0;
    tick(3);
    reset = 1'b0;
    run_cmp = 1'b1;
    tick(1);

    // Reset state and readback of every index, including out-of-range.
    chk("busy_after_reset", 64'(bus.busy_o), 64'd0);
    chk("err_after_reset", 64'(bus.err_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_i = 4'(i);
      tick(1);
      chk("readback_reset", 64'(bus.rd_data_o), 64'h00);
    end

    // Basic write of two registers.
    wq.delete();
    do_start(1);
    send_byte(8'h02, 3);
    send_byte(8'hA5, 3);
    send_byte(8'h3C, 3);
    chk("busy_open", 64'(bus.busy_o), 64'd1);
    do_stop(1);
    chk("busy_closed", 64'(bus.busy_o), 64'd0);
    chk("reg2", 64'(reg_of(2)), 64'hA5);
    chk("reg3", 64'(reg_of(3)), 64'h3C);
    chk("strobes_t2", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("addr0_t2", 64'(wq[0]), 64'd2);
      chk("addr1_t2", 64'(wq[1]), 64'd3);
    end
    bus.rd_addr_i = 4'd2;
    tick(1);
    chk("readback_reg2", 64'(bus.rd_data_o), 64'hA5);

    // Pointer wrap from 7 to 0; stop coincident with the last byte.
    wq.delete();
    do_start(1);
    send_byte(8'h07, 3);
    send_byte(8'h11, 3);
    bus.data_i = 8'h22; bus.data_valid_i = 1'b1; bus.stop_i = 1'b1;
    tick(1);
    bus.stop_i = 1'b0;
    tick(2);
    bus.data_valid_i = 1'b0;
    tick(2);
    chk("reg7", 64'(reg_of(7)), 64'h11);
    chk("reg0_wrap", 64'(reg_of(0)), 64'h22);
    chk("strobes_t3", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("addr0_t3", 64'(wq[0]), 64'd7);
      chk("addr1_t3", 64'(wq[1]), 64'd0);
    end
    chk("busy_after_stop_evt", 64'(bus.busy_o), 64'd0);

    // Out-of-range pointer: error, bytes dropped; next start clears error.
    wq.delete();
    do_start(1);
    send_byte(8'h09, 3);
    send_byte(8'h55, 3);
    chk("err_set", 64'(bus.err_o), 64'd1);
    chk("strobes_t4", 64'(wq.size()), 64'd0);
    chk("regs_unchanged_t4", 64'(bus.regs_o), 64'h1100_0000_3CA5_0022);
    do_start(3);
    chk("err_cleared", 64'(bus.err_o), 64'd0);
    chk("busy_ptr", 64'(bus.busy_o), 64'd1);
    do_stop(2);

    // Long byte-valid levels: one write per rising edge.
    wq.delete();
    do_start(1);
    send_byte(8'h05, 50);
    send_byte(8'h81, 50);
    send_byte(8'h82, 50);
    do_stop(1);
    chk("reg5", 64'(reg_of(5)), 64'h81);
    chk("reg6", 64'(reg_of(6)), 64'h82);
    chk("strobes_t5", 64'(wq.size()), 64'd2);

    // Byte coincident with start is discarded; pointer comes next.
    wq.delete();
    bus.data_i = 8'h01; bus.data_valid_i = 1'b1; bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    tick(5);
    bus.data_valid_i = 1'b0;
    tick(2);
    send_byte(8'h04, 3);
    send_byte(8'h66, 3);
    do_stop(1);
    chk("reg4", 64'(reg_of(4)), 64'h66);
    chk("reg1_untouched", 64'(reg_of(1)), 64'h00);
    chk("strobes_coinc", 64'(wq.size()), 64'd1);

    // Stale byte-valid already high at start produces no event.
    wq.delete();
    bus.data_i = 8'h03; bus.data_valid_i = 1'b1;
    tick(2);
    do_start(1);
    tick(3);
    bus.data_valid_i = 1'b0;
    tick(2);
    send_byte(8'h02, 3);
    send_byte(8'h99, 3);
    do_stop(1);
    chk("reg2_stale", 64'(reg_of(2)), 64'h99);
    chk("reg3_stale", 64'(reg_of(3)), 64'h3C);
    chk("strobes_stale", 64'(wq.size()), 64'd1);

    // Write/readback collision returns the old value, then the new one.
    bus.rd_addr_i = 4'd1;
    do_start(1);
    send_byte(8'h01, 3);
    bus.data_i = 8'hC3; bus.data_valid_i = 1'b1;
    tick(1);
    chk("collision_old", 64'(bus.rd_data_o), 64'h00);
    tick(1);
    chk("collision_new", 64'(bus.rd_data_o), 64'hC3);
    bus.data_valid_i = 1'b0;
    tick(2);

    // Reset between data bytes, then a byte without start is ignored.
    wq.delete();
    send_byte(8'h10, 3);
    #3 reset = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    tick(1);
    send_byte(8'h77, 3);
    chk("regs_after_reset", 64'(bus.regs_o), 64'h0);
    chk("busy_after_midreset", 64'(bus.busy_o), 64'd0);
    chk("strobes_after_reset", 64'(wq.size()), 64'd1);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
